// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared decode constants, enums and helpers for the PCPI mul/div unit
package mdu_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    F3_MUL, F3_MULH, F3_MULHSU, F3_MULHU, F3_DIV, F3_DIVU, F3_REM, F3_REMU
  } funct3_e;

  typedef enum logic [2:0] {
    ST_IDLE, ST_MUL, ST_DIV, ST_FIX, ST_DONE
  } state_e;

  function automatic logic is_div(input funct3_e f);
    return f[2];
  endfunction

  function automatic logic is_signed(input funct3_e f);
    return (f == F3_DIV) || (f == F3_REM);
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// rtl/mdu_div_step.sv - combinational restoring-division step producing DIV_STEP quotient bits
module mdu_div_step #(
  parameter int XLEN     = 32,
  parameter int DIV_STEP = 1
) (
  input  logic [XLEN-1:0]     rem_i,
  input  logic [DIV_STEP-1:0] bits_i,
  input  logic [XLEN-1:0]     divisor_i,
  output logic [XLEN-1:0]     rem_o,
  output logic [DIV_STEP-1:0] quo_o
);

  logic [XLEN:0] r;

  // The partial remainder stays below the divisor, so the dropped top bit is always zero.
  always_comb begin
    r     = {1'b0, rem_i};
    quo_o = '0;
    for (int i = DIV_STEP - 1; i >= 0; i--) begin
      r = {r[XLEN-1:0], bits_i[i]};
      if (r >= {1'b0, divisor_i}) begin
        r        = r - {1'b0, divisor_i};
        quo_o[i] = 1'b1;
      end
    end
    rem_o = r[XLEN-1:0];
  end

endmodule

// File: rtl/pcpi_mdu_seq.sv
// rtl/pcpi_mdu_seq.sv - sequential PCPI multiply/divide unit with divide result reuse
module pcpi_mdu_seq
  import mdu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int DIV_STEP = 1,
  parameter bit EN_CACHE = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pcpi_valid,
  input  logic [31:0]     pcpi_insn,
  input  logic [XLEN-1:0] pcpi_rs1,
  input  logic [XLEN-1:0] pcpi_rs2,
  output logic            pcpi_wr,
  output logic [XLEN-1:0] pcpi_rd,
  output logic            pcpi_wait,
  output logic            pcpi_ready
);

  localparam int NSTEP = XLEN / DIV_STEP;
  localparam int CW    = $clog2(NSTEP);

  state_e          state_q, state_d;
  funct3_e         f3_q, f3_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, quo_q, quo_d, rem_q, rem_d;
  logic [XLEN-1:0] dvs_q, dvs_d, res_q, res_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sgn_q, sgn_d, negq_q, negq_d, negr_q, negr_d, cool_q, cool_d;
  logic            cv_q, cv_d, csgn_q, csgn_d;
  logic [XLEN-1:0] ca_q, ca_d, cb_q, cb_d, cquo_q, cquo_d, crem_q, crem_d;

  funct3_e         f3_in;
  logic            hit, accept, sgn_in, rs1_neg, rs2_neg, div_zero, ovf, c_hit;
  logic [XLEN-1:0] mag1, mag2, fq, fr, step_rem;
  logic [DIV_STEP-1:0] step_quo;
  logic [2*XLEN+1:0]   mul_a, mul_b, prod;
  logic            unused_bits;

  assign f3_in    = funct3_e'(pcpi_insn[14:12]);
  assign hit      = (pcpi_insn[6:0] == OPCODE_OP) && (pcpi_insn[31:25] == FUNCT7_MULDIV);
  assign accept   = (state_q == ST_IDLE) && pcpi_valid && hit && !cool_q;
  assign sgn_in   = is_signed(f3_in);
  assign rs1_neg  = sgn_in & pcpi_rs1[XLEN-1];
  assign rs2_neg  = sgn_in & pcpi_rs2[XLEN-1];
  assign mag1     = rs1_neg ? -pcpi_rs1 : pcpi_rs1;
  assign mag2     = rs2_neg ? -pcpi_rs2 : pcpi_rs2;
  assign div_zero = (pcpi_rs2 == '0);
  assign ovf      = sgn_in && (pcpi_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (&pcpi_rs2);
  assign c_hit    = EN_CACHE && cv_q && (ca_q == pcpi_rs1) && (cb_q == pcpi_rs2) && (csgn_q == sgn_in);

  // Operands are sign-extended to the full product width so one unsigned multiply covers all variants.
  assign mul_a = {{(XLEN+2){((f3_q == F3_MULH) || (f3_q == F3_MULHSU)) & a_q[XLEN-1]}}, a_q};
  assign mul_b = {{(XLEN+2){(f3_q == F3_MULH) & b_q[XLEN-1]}}, b_q};
  assign prod  = mul_a * mul_b;

  assign fq = negq_q ? -quo_q : quo_q;
  assign fr = negr_q ? -rem_q : rem_q;

  assign unused_bits = ^{pcpi_insn[24:15], pcpi_insn[11:7], prod[2*XLEN+1:2*XLEN]};

  mdu_div_step #(.XLEN(XLEN), .DIV_STEP(DIV_STEP)) u_step (
    .rem_i     (rem_q),
    .bits_i    (quo_q[XLEN-1 -: DIV_STEP]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  always_comb begin
    state_d = state_q;  f3_d   = f3_q;   a_d    = a_q;    b_d    = b_q;
    quo_d   = quo_q;    rem_d  = rem_q;  dvs_d  = dvs_q;  res_d  = res_q;
    cnt_d   = cnt_q;    sgn_d  = sgn_q;  negq_d = negq_q; negr_d = negr_q;
    cv_d    = cv_q;     csgn_d = csgn_q; ca_d   = ca_q;   cb_d   = cb_q;
    cquo_d  = cquo_q;   crem_d = crem_q; cool_d = 1'b0;
    pcpi_wait  = 1'b0;
    pcpi_ready = 1'b0;
    pcpi_wr    = 1'b0;
    pcpi_rd    = '0;
    unique case (state_q)
      ST_IDLE: if (accept) begin
        pcpi_wait = 1'b1;
        f3_d  = f3_in;
        a_d   = pcpi_rs1;
        b_d   = pcpi_rs2;
        sgn_d = sgn_in;
        if (!is_div(f3_in)) begin
          cv_d    = 1'b0;
          state_d = ST_MUL;
        end else if (div_zero) begin
          res_d   = f3_in[1] ? pcpi_rs1 : '1;
          state_d = ST_DONE;
        end else if (ovf) begin
          res_d   = f3_in[1] ? '0 : pcpi_rs1;
          state_d = ST_DONE;
        end else if (c_hit) begin
          res_d   = f3_in[1] ? crem_q : cquo_q;
          state_d = ST_DONE;
        end else begin
          quo_d   = mag1;
          rem_d   = '0;
          dvs_d   = mag2;
          negq_d  = rs1_neg ^ rs2_neg;
          negr_d  = rs1_neg;
          cnt_d   = CW'(NSTEP - 1);
          state_d = ST_DIV;
        end
      end
      ST_MUL: begin
        pcpi_wait = 1'b1;
        if (!pcpi_valid) begin
          state_d = ST_IDLE;
        end else begin
          res_d   = (f3_q == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
          state_d = ST_DONE;
        end
      end
      ST_DIV: begin
        pcpi_wait = 1'b1;
        if (!pcpi_valid) begin
          cv_d    = 1'b0;
          state_d = ST_IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = {quo_q[XLEN-DIV_STEP-1:0], step_quo};
          if (cnt_q == '0) state_d = ST_FIX;
          else             cnt_d   = cnt_q - CW'(1);
        end
      end
      ST_FIX: begin
        pcpi_wait = 1'b1;
        if (!pcpi_valid) begin
          cv_d    = 1'b0;
          state_d = ST_IDLE;
        end else begin
          res_d   = f3_q[1] ? fr : fq;
          cv_d    = EN_CACHE;
          ca_d    = a_q;
          cb_d    = b_q;
          csgn_d  = sgn_q;
          cquo_d  = fq;
          crem_d  = fr;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        pcpi_wait  = 1'b1;
        pcpi_ready = 1'b1;
        pcpi_wr    = 1'b1;
        pcpi_rd    = res_q;
        cool_d     = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE; f3_q  <= F3_MUL; a_q    <= '0;   b_q    <= '0;
      quo_q   <= '0;      rem_q <= '0;     dvs_q  <= '0;   res_q  <= '0;
      cnt_q   <= '0;      sgn_q <= 1'b0;   negq_q <= 1'b0; negr_q <= 1'b0;
      cv_q    <= 1'b0;    csgn_q <= 1'b0;  ca_q   <= '0;   cb_q   <= '0;
      cquo_q  <= '0;      crem_q <= '0;    cool_q <= 1'b0;
    end else begin
      state_q <= state_d; f3_q  <= f3_d;   a_q    <= a_d;    b_q    <= b_d;
      quo_q   <= quo_d;   rem_q <= rem_d;  dvs_q  <= dvs_d;  res_q  <= res_d;
      cnt_q   <= cnt_d;   sgn_q <= sgn_d;  negq_q <= negq_d; negr_q <= negr_d;
      cv_q    <= cv_d;    csgn_q <= csgn_d; ca_q  <= ca_d;   cb_q   <= cb_d;
      cquo_q  <= cquo_d;  crem_q <= crem_d; cool_q <= cool_d;
    end
  end

endmodule

// File: tb/tb_pcpi_mdu_seq.sv
// tb/tb_pcpi_mdu_seq.sv - directed self-checking bench for pcpi_mdu_seq (DIV_STEP 1 and 4)
module tb_pcpi_mdu_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] insn, rs1, rs2;
  logic        valid   [2];
  logic        wr_o    [2];
  logic        wait_o  [2];
  logic        ready_o [2];
  logic [31:0] rd_o    [2];

  logic        ew  [2];
  logic        er  [2];
  logic [31:0] erd [2];

  int          nstep [2] = '{32, 8};
  bit          cv [2];
  bit          cs [2];
  logic [31:0] ca [2];
  logic [31:0] cb [2];

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  bit          pin_on = 1'b0;
  int          pin_id, pin_lm, pin_ll;
  logic [31:0] pin_rm, pin_rl;

  pcpi_mdu_seq #(.XLEN(32), .DIV_STEP(1), .EN_CACHE(1'b1)) dut1 (
    .clk(clk), .reset(reset), .pcpi_valid(valid[0]), .pcpi_insn(insn),
    .pcpi_rs1(rs1), .pcpi_rs2(rs2), .pcpi_wr(wr_o[0]), .pcpi_rd(rd_o[0]),
    .pcpi_wait(wait_o[0]), .pcpi_ready(ready_o[0])
  );

  pcpi_mdu_seq #(.XLEN(32), .DIV_STEP(4), .EN_CACHE(1'b1)) dut4 (
    .clk(clk), .reset(reset), .pcpi_valid(valid[1]), .pcpi_insn(insn),
    .pcpi_rs1(rs1), .pcpi_rs2(rs2), .pcpi_wr(wr_o[1]), .pcpi_rd(rd_o[1]),
    .pcpi_wait(wait_o[1]), .pcpi_ready(ready_o[1])
  );

  task automatic check(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d t=%0t actual=%h required=%h", nm, d, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        check("wait", d, {31'b0, wait_o[d]}, {31'b0, ew[d]});
        check("ready", d, {31'b0, ready_o[d]}, {31'b0, er[d]});
        check("wr", d, {31'b0, wr_o[d]}, {31'b0, er[d]});
        check("rd", d, rd_o[d], erd[d]);
      end
    end
    if (pin_on) begin
      check("model_result", pin_id, pin_rm, pin_rl);
      check("model_latency", pin_id, pin_lm, pin_ll);
    end
  end

  function automatic logic [31:0] mk_insn(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  // Plain-arithmetic reference: result and cycles from accept to ready.
  function automatic void model(input int d, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output int lat, output bit full_div);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    logic [63:0]     p;
    bit              sgn;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    full_div = 1'b0;
    res = '0;
    lat = 2;
    case (f3)
      3'd0: begin p = ua * ub;           res = p[31:0];  end
      3'd1: begin p = sa * sb;           res = p[63:32]; end
      3'd2: begin p = sa * longint'(ub); res = p[63:32]; end
      3'd3: begin p = ua * ub;           res = p[63:32]; end
      default: begin
        sgn = (f3 == 3'd4) || (f3 == 3'd6);
        if (b == 32'd0) begin
          res = f3[1] ? a : 32'hFFFF_FFFF;
          lat = 1;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          res = f3[1] ? 32'd0 : a;
          lat = 1;
        end else begin
          if (sgn) begin
            sq = sa / sb; sr = sa % sb;
            res = f3[1] ? sr[31:0] : sq[31:0];
          end else begin
            uq = ua / ub; ur = ua % ub;
            res = f3[1] ? ur[31:0] : uq[31:0];
          end
          if (cv[d] && ca[d] == a && cb[d] == b && cs[d] == sgn) lat = 1;
          else begin
            lat = nstep[d] + 2;
            full_div = 1'b1;
          end
        end
      end
    endcase
  endfunction

  task automatic step_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int d, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] lres, input int llat, input int stop_at, input bit use_reset);
    logic [31:0] res;
    int          lat;
    bit          full_div;
    model(d, f3, a, b, res, lat, full_div);
    insn = mk_insn(7'b0000001, f3);
    rs1 = a;
    rs2 = b;
    valid[d] = 1'b1;
    ew[d] = 1'b1; er[d] = 1'b0; erd[d] = '0;
    if (stop_at == 0) begin
      pin_id = d; pin_rm = res; pin_rl = lres; pin_lm = lat; pin_ll = llat; pin_on = 1'b1;
    end
    step_cycle();
    pin_on = 1'b0;
    rs1 = $urandom;
    rs2 = $urandom;
    if (stop_at == 0) begin
      for (int c = 1; c <= lat; c++) begin
        ew[d] = 1'b1; er[d] = (c == lat); erd[d] = (c == lat) ? res : 32'd0;
        step_cycle();
      end
      ew[d] = 1'b0; er[d] = 1'b0; erd[d] = '0;
      step_cycle();
      valid[d] = 1'b0;
      if (f3[2] == 1'b0) cv[d] = 1'b0;
      else if (full_div) begin
        cv[d] = 1'b1; ca[d] = a; cb[d] = b; cs[d] = (f3 == 3'd4) || (f3 == 3'd6);
      end
    end else begin
      for (int c = 1; c < stop_at; c++) begin
        ew[d] = 1'b1; er[d] = 1'b0; erd[d] = '0;
        step_cycle();
      end
      valid[d] = 1'b0;
      if (use_reset) reset = 1'b1;
      ew[d] = 1'b1;
      step_cycle();
      reset = 1'b0;
      ew[d] = 1'b0;
      step_cycle();
      cv[d] = 1'b0;
      if (use_reset) cv = '{1'b0, 1'b0};
    end
  endtask

  initial begin
    reset = 1'b1;
    insn = '0; rs1 = '0; rs2 = '0;
    for (int d = 0; d < 2; d++) begin
      valid[d] = 1'b0; ew[d] = 1'b0; er[d] = 1'b0; erd[d] = '0;
      cv[d] = 1'b0; cs[d] = 1'b0; ca[d] = '0; cb[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    step_cycle();
    reset = 1'b0;

    issue(0, 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 0, 0);
    issue(0, 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1, 0, 0);
    issue(0, 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2, 0, 0);
    issue(0, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 0, 0);
    issue(0, 3'd0, 32'd7, 32'd6, 32'd42, 2, 0, 0);
    issue(0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, 0, 0);
    issue(0, 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0, 0);
    issue(0, 3'd6, 32'd5, 32'd0, 32'd5, 1, 0, 0);
    issue(0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, 0);
    issue(0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0, 0);
    issue(0, 3'd4, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 34, 0, 0);
    issue(0, 3'd6, 32'd100, 32'hFFFF_FFF9, 32'd2, 1, 0, 0);
    issue(0, 3'd4, 32'd1000, 32'd3, 32'd333, 34, 5, 0);
    issue(0, 3'd6, 32'd100, 32'hFFFF_FFF9, 32'd2, 34, 0, 0);
    issue(0, 3'd7, 32'hFFFF_FFFF, 32'h10, 32'hF, 34, 0, 0);

    issue(1, 3'd5, 32'd100, 32'd7, 32'd14, 10, 0, 0);
    issue(1, 3'd7, 32'd100, 32'd7, 32'd2, 1, 0, 0);
    issue(1, 3'd4, 32'd100, 32'd7, 32'd14, 10, 0, 0);
    issue(1, 3'd0, 32'd3, 32'd5, 32'd15, 2, 0, 0);
    issue(1, 3'd7, 32'd100, 32'd7, 32'd2, 10, 0, 0);
    issue(1, 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 10, 0, 0);

    issue(0, 3'd5, 32'd12345, 32'd67, 32'd184, 34, 3, 1);
    issue(1, 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 10, 0, 0);
    issue(0, 3'd5, 32'd12345, 32'd67, 32'd184, 34, 0, 0);
    issue(0, 3'd7, 32'd12345, 32'd67, 32'd17, 1, 0, 0);

    insn = mk_insn(7'b0000000, 3'd4);
    rs1 = 32'd9; rs2 = 32'd3;
    valid[0] = 1'b1; valid[1] = 1'b1;
    repeat (3) step_cycle();
    insn = {7'b0000001, 5'd2, 5'd1, 3'd4, 5'd3, 7'b0010011};
    repeat (3) step_cycle();
    valid[0] = 1'b0; valid[1] = 1'b0;
    repeat (3) step_cycle();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pcpi_mdu_seq.md
PCPI_MDU_SEQ -- requirements
Module: pcpi_mdu_seq

Interface
REQ-001 SHALL have parameters: XLEN, default 32, data width; DIV_STEP, default 1, quotient bits per divide cycle (1, 2 or 4, must divide XLEN); EN_CACHE, default 1, enables DIV/REM result reuse.
REQ-002 SHALL have ports:
- clk  in  1  sole clock; one clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- pcpi_valid  in  1  core offers instruction.
- pcpi_insn  in  32  instruction word.
- pcpi_rs1  in  XLEN  operand 1.
- pcpi_rs2  in  XLEN  operand 2.
- pcpi_wr  out  1  write rd.
- pcpi_rd  out  XLEN  result.
- pcpi_wait  out  1  instruction claimed, result pending.
- pcpi_ready  out  1  result valid, 1-cycle pulse.

Function
REQ-003 SHALL decode a hit when opcode=0110011 and funct7=0000001; funct3 selects MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM or REMU.
REQ-004 SHALL implement states IDLE, MUL, DIV, FIX, DONE; accept occurs in IDLE when pcpi_valid and hit and not cooldown; accept cycle = T.
REQ-005 SHALL capture funct3, rs1 and rs2 at T; later operand changes SHALL NOT affect the result.
REQ-006 Multiply: IDLE->MUL->DONE; the (XLEN+1)x(XLEN+1) signed product uses sign extension per funct3 (MULH s*s, MULHSU s*u, MULHU/MUL u*u); MUL returns the low XLEN bits, others the high XLEN bits; pcpi_ready SHALL be at T+2.
REQ-007 Divide: restoring division on magnitudes, DIV_STEP bits per cycle, iteration counter XLEN/DIV_STEP-1 down to 0; DIV lasts XLEN/DIV_STEP cycles, then FIX (sign correction), then DONE; pcpi_ready SHALL be at T+XLEN/DIV_STEP+2.
REQ-008 Signed quotient SHALL be negated when operand signs differ; signed remainder SHALL take the sign of rs1.
REQ-009 Divide by zero SHALL give quotient all-ones and remainder = rs1, going IDLE->DONE with ready at T+1.
REQ-010 Signed overflow (rs1 = -2^(XLEN-1), rs2 = -1) SHALL give DIV = rs1 and REM = 0, with ready at T+1.
REQ-011 With EN_CACHE=1, each completed divide SHALL store rs1, rs2, signedness, quotient and remainder; a later DIV/REM/DIVU/REMU with equal rs1, rs2 and signedness SHALL finish IDLE->DONE with ready at T+1.
REQ-012 Any multiply, reset, or aborted divide SHALL invalidate the cache.
REQ-013 pcpi_wait SHALL be high combinationally in IDLE on an accepting hit, and in MUL, DIV, FIX and DONE; low otherwise.
REQ-014 In DONE, pcpi_ready and pcpi_wr SHALL be 1 for exactly one cycle with pcpi_rd valid; outside DONE, pcpi_rd SHALL be 0; DONE->IDLE unconditionally.
REQ-015 The cycle after DONE SHALL be a cooldown: no accept even if pcpi_valid is high.
REQ-016 If pcpi_valid falls in MUL, DIV or FIX, the block SHALL return to IDLE next cycle without a ready pulse (abort).
REQ-017 Non-hit instructions SHALL be ignored: no wait, no ready.

Reset
REQ-018 Reset SHALL be synchronous and active-high, winning over all other events including mid-operation.
REQ-019 Reset SHALL force state IDLE, counter 0, cache invalid, cooldown 0, and outputs pcpi_wr=0, pcpi_ready=0, pcpi_wait=0, pcpi_rd=0.

Structure
REQ-020 A shared package (mdu_pkg) SHALL hold the opcode/funct7 constants, the funct3 enum, the state enum, and the is_div/is_signed helper functions.
REQ-021 Sub-module mdu_div_step SHALL be the combinational DIV_STEP-bit restoring step (inputs remainder, dividend bits, divisor; outputs next remainder and quotient bits).
REQ-022 There SHALL be exactly one multiplier instance; no other sub-modules.

Verification (XLEN=32)
REQ-023 DIV_STEP=1: DIV rs1=0xFFFFFFF9, rs2=2 -> pcpi_rd=0xFFFFFFFD at T+34; REM on the same operands -> 0xFFFFFFFF at T+1 (cache hit).
REQ-024 Multiplies: MULH 0x80000000*0x80000000 -> 0x40000000 at T+2; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF; MUL 7*6 -> 42.
REQ-025 Special cases: DIVU 5/0 -> 0xFFFFFFFF at T+1; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
REQ-026 DIV_STEP=4: DIVU 100/7 -> 14 at T+10; REMU 100/7 -> 2.
REQ-027 Abort and reset: pcpi_valid dropped at T+5 of a DIV -> IDLE at T+6, no ready, cache invalid; reset asserted mid-DIV -> all outputs 0 next cycle.
REQ-028 Cooldown: pcpi_valid held high through DONE -> no second accept in the cycle after DONE, exactly one ready pulse.
